// File: rtl/demux_stream_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | demux_stream_router                                                      |
// | Registered 1-to-NUM_CH valid/ready demultiplexer, one holding register   |
// | per channel. Define DEMUX_DROP_CNT_EN to add the drop_cnt port/counter.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module demux_stream_router #(
   parameter int DATA_W = 8,
   parameter int NUM_CH = 8,
   parameter int SEL_W  = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [SEL_W-1:0]         in_sel,
   output logic [NUM_CH-1:0]        out_valid,
   input  logic [NUM_CH-1:0]        out_ready,
   output logic [NUM_CH*DATA_W-1:0] out_data
`ifdef DEMUX_DROP_CNT_EN
   ,
   output logic [15:0]              drop_cnt
`endif
);

   logic [NUM_CH-1:0] w_hit;
   logic [NUM_CH-1:0] w_busy;
   logic              w_xfer;

   // An out-of-range select hits no channel, so it is never blocked.
   assign in_ready = !rst && !(|(w_hit & w_busy));
   assign w_xfer   = in_valid && in_ready;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      localparam logic [SEL_W-1:0] c_idx = SEL_W'(k);
      logic              r_valid;
      logic [DATA_W-1:0] r_data;

      assign w_hit[k]  = (in_sel == c_idx);
      assign w_busy[k] = r_valid && !out_ready[k];

      // A load wins over a drain, giving back-to-back throughput.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
         end else if (w_xfer && w_hit[k]) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
         end else if (out_ready[k]) begin
            r_valid <= 1'b0;
         end
      end

      assign out_valid[k]                     = r_valid;
      assign out_data[k*DATA_W +: DATA_W]     = r_data;
   end

`ifdef DEMUX_DROP_CNT_EN
   logic [15:0] r_drop_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_drop_cnt <= '0;
      end else if (w_xfer && !(|w_hit) && (r_drop_cnt != 16'hFFFF)) begin
         r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   assign drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire
